// File: rtl/matrix_result_reader.sv
// Waits for every core to report done, then streams the result matrix out of
// shared data memory one element per valid/ready handshake.
module matrix_result_reader #(
    parameter int                    NUM_CORES    = 4,
    parameter int                    ADDR_WIDTH   = 8,
    parameter int                    DATA_WIDTH   = 8,
    parameter logic [ADDR_WIDTH-1:0] RESULT_BASE  = '0,
    parameter int                    RESULT_COUNT = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start_process,
    input  logic [NUM_CORES-1:0]  core_done,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  busy,
    output logic                  process_done
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_CORES,
        ISSUE,
        CAPTURE,
        PRESENT,
        DONE
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(RESULT_COUNT - 1);

    state_t                  state_q, state_d;
    logic [NUM_CORES-1:0]    done_latch_q, done_latch_d;
    logic [ADDR_WIDTH-1:0]   index_q, index_d;
    logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
    logic                    out_last_q, out_last_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            done_latch_q <= '0;
            index_q      <= '0;
            out_data_q   <= '0;
            out_last_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            done_latch_q <= done_latch_d;
            index_q      <= index_d;
            out_data_q   <= out_data_d;
            out_last_q   <= out_last_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        done_latch_d = done_latch_q;
        index_d      = index_q;
        out_data_d   = out_data_q;
        out_last_d   = out_last_q;
        case (state_q)
            IDLE: begin
                done_latch_d = '0;
                index_d      = '0;
                if (start_process) state_d = WAIT_CORES;
            end
            WAIT_CORES: begin
                // Latch is sticky so staggered single-cycle done pulses accumulate.
                done_latch_d = done_latch_q | core_done;
                if (&done_latch_d) state_d = ISSUE;
            end
            ISSUE: state_d = CAPTURE;
            CAPTURE: begin
                out_data_d = mem_rdata;
                out_last_d = (index_q == LAST_IDX);
                state_d    = PRESENT;
            end
            PRESENT: begin
                if (out_ready) begin
                    if (out_last_q) begin
                        state_d = DONE;
                    end else begin
                        index_d = index_q + 1'b1;
                        state_d = ISSUE;
                    end
                end
            end
            DONE: if (!start_process) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_rd_en    = (state_q == ISSUE);
        mem_addr     = (state_q == ISSUE) ? RESULT_BASE + index_q : '0;
        out_data     = out_data_q;
        out_valid    = (state_q == PRESENT);
        // out_last_q persists after the stream; only drive it while presenting.
        out_last     = (state_q == PRESENT) && out_last_q;
        busy         = (state_q != IDLE) && (state_q != DONE);
        process_done = (state_q == DONE);
    end

endmodule

// File: tb/tb_matrix_result_reader.sv
// Scoreboard bench for matrix_result_reader: default instance plus a wrapping
// instance with RESULT_BASE=FE, RESULT_COUNT=4 sharing one memory model.
module tb_matrix_result_reader;

    logic       clock = 1'b0;
    logic       reset;
    logic       start_process;
    logic [3:0] core_done;
    logic       mem_rd_en;
    logic [7:0] mem_addr;
    logic [7:0] mem_rdata;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;
    logic       busy;
    logic       process_done;

    logic       start_b;
    logic [3:0] core_done_b;
    logic       mem_rd_en_b;
    logic [7:0] mem_addr_b;
    logic [7:0] mem_rdata_b;
    logic [7:0] out_data_b;
    logic       out_valid_b;
    logic       out_last_b;
    logic       busy_b;
    logic       process_done_b;

    logic [7:0] mem [256];

    int total = 0;
    int bad   = 0;
    int n_hs  = 0;
    int n_rd  = 0;

    logic [7:0] addr_q [$];
    logic [7:0] data_q [$];
    logic       last_q [$];
    logic [7:0] exp_a;
    logic [7:0] exp_d;
    logic       exp_l;

    always #5 clock = ~clock;

    matrix_result_reader #(
        .NUM_CORES(4), .ADDR_WIDTH(8), .DATA_WIDTH(8),
        .RESULT_BASE(8'h00), .RESULT_COUNT(16)
    ) dut (
        .clock(clock), .reset(reset), .start_process(start_process),
        .core_done(core_done), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last), .busy(busy),
        .process_done(process_done)
    );

    matrix_result_reader #(
        .NUM_CORES(4), .ADDR_WIDTH(8), .DATA_WIDTH(8),
        .RESULT_BASE(8'hFE), .RESULT_COUNT(4)
    ) dut_wrap (
        .clock(clock), .reset(reset), .start_process(start_b),
        .core_done(core_done_b), .mem_rd_en(mem_rd_en_b), .mem_addr(mem_addr_b),
        .mem_rdata(mem_rdata_b), .out_data(out_data_b), .out_valid(out_valid_b),
        .out_ready(1'b1), .out_last(out_last_b), .busy(busy_b),
        .process_done(process_done_b)
    );

    // Synchronous memory: data valid one cycle after the read strobe.
    always @(posedge clock) begin
        if (mem_rd_en)   mem_rdata   <= mem[mem_addr];
        if (mem_rd_en_b) mem_rdata_b <= mem[mem_addr_b];
    end

    // Scoreboard for the default instance.
    always @(negedge clock) begin
        if (!reset) begin
            if (mem_rd_en) begin
                n_rd++;
                total++;
                if (addr_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_read addr=%h required=no read", mem_addr);
                end else begin
                    exp_a = addr_q.pop_front();
                    if (mem_addr !== exp_a) begin
                        bad++;
                        $display("FAIL read_addr got=%h required=%h", mem_addr, exp_a);
                    end
                end
            end
            if (out_valid && out_ready) begin
                n_hs++;
                total++;
                if (data_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_handshake data=%h required=none", out_data);
                end else begin
                    exp_d = data_q.pop_front();
                    exp_l = last_q.pop_front();
                    if ({out_data, out_last} !== {exp_d, exp_l}) begin
                        bad++;
                        $display("FAIL stream_elem got=%h/%b required=%h/%b",
                                 out_data, out_last, exp_d, exp_l);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic push_readout();
        for (int i = 0; i < 16; i++) begin
            addr_q.push_back(8'(i));
            data_q.push_back(mem[i]);
            last_q.push_back(i == 15);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (process_done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        total++;
        if ({mem_rd_en, mem_addr, out_data, out_valid, out_last, busy, process_done} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got=%b required=0",
                     {mem_rd_en, mem_addr, out_data, out_valid, out_last, busy, process_done});
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        bit ok;
        int h0 = n_hs;
        int r0 = n_rd;
        start_process = 1'b1;
        core_done     = '0;
        tick();
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL basic_busy_wait got=%b required=1", busy);
        end
        repeat (9) tick();
        push_readout();
        core_done = 4'b1111;
        tick();
        core_done = '0;
        wait_done(ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL basic_done_timeout got=0 required=1");
        end
        total++;
        if ((n_hs - h0) != 16 || (n_rd - r0) != 16) begin
            bad++;
            $display("FAIL basic_counts hs=%0d rd=%0d required=16/16", n_hs - h0, n_rd - r0);
        end
        total++;
        if ({busy, process_done, out_valid} !== 3'b010) begin
            bad++;
            $display("FAIL basic_final busy/done/valid=%b required=010",
                     {busy, process_done, out_valid});
        end
    endtask

    task automatic test_held_start();
        bit ok;
        int r0 = n_rd;
        int h0;
        repeat (50) tick();
        total++;
        if (process_done !== 1'b1 || n_rd != r0) begin
            bad++;
            $display("FAIL held_start done=%b reads=%0d required=1/0", process_done, n_rd - r0);
        end
        start_process = 1'b0;
        tick();
        start_process = 1'b1;
        core_done     = 4'b1111;
        push_readout();
        h0 = n_hs;
        tick();
        tick();
        core_done = '0;
        wait_done(ok);
        total++;
        if (!ok || (n_hs - h0) != 16) begin
            bad++;
            $display("FAIL rearm_readout ok=%b hs=%0d required=1/16", ok, n_hs - h0);
        end
        start_process = 1'b0;
        tick();
        tick();
        total++;
        if ({busy, process_done} !== 2'b00) begin
            bad++;
            $display("FAIL rearm_idle busy/done=%b required=00", {busy, process_done});
        end
    endtask

    task automatic test_staggered();
        bit ok;
        int r0 = n_rd;
        start_process = 1'b1;
        tick();
        core_done = 4'b0001; tick(); core_done = '0; tick();
        core_done = 4'b0100; tick(); core_done = '0; tick();
        core_done = 4'b0010; tick(); core_done = '0;
        repeat (3) tick();
        push_readout();
        core_done = 4'b1000;
        total++;
        if (mem_rd_en !== 1'b0 || n_rd != r0) begin
            bad++;
            $display("FAIL stagger_early_read rd_en=%b reads=%0d required=0/0", mem_rd_en, n_rd - r0);
        end
        tick();
        core_done = '0;
        total++;
        if ({mem_rd_en, mem_addr} !== {1'b1, 8'h00}) begin
            bad++;
            $display("FAIL stagger_first_read rd_en/addr=%b/%h required=1/00", mem_rd_en, mem_addr);
        end
        wait_done(ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL stagger_done_timeout got=0 required=1");
        end
        start_process = 1'b0;
        tick();
        tick();
        // Control run: core 3 never reports, so nothing may be read.
        r0 = n_rd;
        start_process = 1'b1;
        tick();
        core_done = 4'b0001; tick(); core_done = 4'b0100; tick();
        core_done = 4'b0010; tick(); core_done = '0;
        repeat (30) tick();
        total++;
        if (busy !== 1'b1 || process_done !== 1'b0 || n_rd != r0) begin
            bad++;
            $display("FAIL stagger_control busy=%b done=%b reads=%0d required=1/0/0",
                     busy, process_done, n_rd - r0);
        end
        start_process = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        bit ok;
        bit found = 1'b0;
        int h0 = n_hs;
        push_readout();
        start_process = 1'b1;
        core_done     = 4'b1111;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (out_valid && out_data == 8'h12) begin
                found = 1'b1;
                break;
            end
        end
        core_done = '0;
        out_ready = 1'b0;
        total++;
        if (!found) begin
            bad++;
            $display("FAIL bp_find_elem2 got=none required=12");
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            total++;
            if ({out_valid, out_data, mem_rd_en} !== {1'b1, 8'h12, 1'b0}) begin
                bad++;
                $display("FAIL bp_hold cyc=%0d valid/data/rd=%b/%h/%b required=1/12/0",
                         i, out_valid, out_data, mem_rd_en);
            end
            tick();
        end
        out_ready = 1'b1;
        wait_done(ok);
        total++;
        if (!ok || (n_hs - h0) != 16) begin
            bad++;
            $display("FAIL bp_complete ok=%b hs=%0d required=1/16", ok, n_hs - h0);
        end
        start_process = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset_midstream();
        bit ok;
        bit found = 1'b0;
        push_readout();
        start_process = 1'b1;
        core_done     = 4'b1111;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (out_valid && out_data == 8'h16) begin
                found = 1'b1;
                break;
            end
        end
        out_ready     = 1'b0;
        core_done     = '0;
        start_process = 1'b0;
        reset         = 1'b1;
        tick();
        total++;
        if (!found ||
            {mem_rd_en, mem_addr, out_data, out_valid, out_last, busy, process_done} !== '0) begin
            bad++;
            $display("FAIL midreset_outputs found=%b got=%b required=0", found,
                     {mem_rd_en, mem_addr, out_data, out_valid, out_last, busy, process_done});
        end
        reset = 1'b0;
        addr_q.delete();
        data_q.delete();
        last_q.delete();
        tick();
        out_ready = 1'b1;
        push_readout();
        start_process = 1'b1;
        core_done     = 4'b1111;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (mem_rd_en) begin
                found = 1'b1;
                break;
            end
        end
        core_done = '0;
        total++;
        if (!found || mem_addr !== 8'h00) begin
            bad++;
            $display("FAIL midreset_restart_addr found=%b addr=%h required=1/00", found, mem_addr);
        end
        wait_done(ok);
        total++;
        if (!ok || addr_q.size() != 0) begin
            bad++;
            $display("FAIL midreset_restart_done ok=%b left=%0d required=1/0", ok, addr_q.size());
        end
        start_process = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_wrap();
        logic [7:0] wexp [4];
        int nr = 0;
        int nh = 0;
        wexp[0] = 8'hFE; wexp[1] = 8'hFF; wexp[2] = 8'h00; wexp[3] = 8'h01;
        start_b     = 1'b1;
        core_done_b = 4'b1111;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (mem_rd_en_b) begin
                total++;
                if (nr >= 4 || mem_addr_b !== wexp[nr & 3]) begin
                    bad++;
                    $display("FAIL wrap_addr n=%0d got=%h required=%h", nr, mem_addr_b, wexp[nr & 3]);
                end
                nr++;
            end
            if (out_valid_b) begin
                total++;
                if (nh >= 4 || {out_data_b, out_last_b} !== {mem[wexp[nh & 3]], nh == 3}) begin
                    bad++;
                    $display("FAIL wrap_data n=%0d got=%h/%b required=%h/%b", nh,
                             out_data_b, out_last_b, mem[wexp[nh & 3]], nh == 3);
                end
                nh++;
            end
            if (process_done_b) break;
        end
        total++;
        if (nr != 4 || nh != 4 || process_done_b !== 1'b1) begin
            bad++;
            $display("FAIL wrap_counts rd=%0d hs=%0d done=%b required=4/4/1", nr, nh, process_done_b);
        end
        start_b     = 1'b0;
        core_done_b = '0;
        tick();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = (i < 16) ? 8'(8'h10 + i) : (8'(i) ^ 8'h5A);
        end
        reset         = 1'b1;
        start_process = 1'b0;
        core_done     = '0;
        out_ready     = 1'b1;
        start_b       = 1'b0;
        core_done_b   = '0;

        test_reset();
        test_basic();
        test_held_start();
        test_staggered();
        test_backpressure();
        test_reset_midstream();
        test_wrap();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/matrix_result_reader.md
Name: matrix_result_reader

Overview:
- Far end of the multicore start/finish protocol. The bench or host raises start_process and the cores execute; this block waits for every core to report done.
- It then reads the result matrix out of shared data memory and streams it out one element at a time over a valid/ready interface.
- It reports process_done when the last element has been accepted.
- It sits beside the data memory in the top level and shares its read port once all cores are idle.

Parameters:
- NUM_CORES, 4, number of core_done inputs.
- ADDR_WIDTH, 8, data memory address width.
- DATA_WIDTH, 8, data memory word width.
- RESULT_BASE, 8'd0, address of the first result element (row-major).
- RESULT_COUNT, 16, number of elements to stream. Must be ≥1 and fit in ADDR_WIDTH.

Ports:
- clock  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- start_process  input  1  level start from host; same signal that launches the cores.
- core_done  input  NUM_CORES  per-core completion pulse or level.
- mem_rd_en  output  1  data memory read strobe.
- mem_addr  output  ADDR_WIDTH  data memory read address.
- mem_rdata  input  DATA_WIDTH  read data; valid exactly 1 cycle after mem_rd_en.
- out_data  output  DATA_WIDTH  streamed result element.
- out_valid  output  1  out_data valid.
- out_ready  input  1  sink accepts when out_valid && out_ready.
- out_last  output  1  high with the final element.
- busy  output  1  high in every state except IDLE and DONE.
- process_done  output  1  high in DONE.

Behaviour:
- Reset: the clocked reset applies in any state, including mid-stream.
  - State goes to IDLE.
  - done_latch=0, index=0.
  - mem_rd_en=0, mem_addr=0, out_data=0, out_valid=0, out_last=0, busy=0, process_done=0.
- States are IDLE, WAIT_CORES, ISSUE, CAPTURE, PRESENT, DONE.
- IDLE:
  - done_latch is cleared and index=0.
  - When start_process=1, go to WAIT_CORES.
- WAIT_CORES:
  - done_latch |= core_done every cycle, so pulses are sticky.
  - When done_latch, after this cycle's OR, is all ones, go to ISSUE on the next edge.
  - An all-ones core_done on the first WAIT_CORES cycle gives 1 cycle in WAIT_CORES.
- ISSUE:
  - mem_rd_en=1 and mem_addr=RESULT_BASE+index for exactly this one cycle.
  - Go to CAPTURE.
- CAPTURE:
  - out_data <= mem_rdata.
  - out_last <= (index==RESULT_COUNT-1).
  - Go to PRESENT.
- PRESENT:
  - out_valid=1.
  - out_data and out_last are held stable until the handshake.
  - On out_valid&&out_ready:
    - If out_last, go to DONE.
    - Otherwise index++ and go to ISSUE.
  - out_valid drops the cycle after acceptance.
  - Minimum 3 cycles per element; one element is transferred per handshake, never duplicated or skipped.
- DONE:
  - process_done=1, all other outputs 0 except out_data, which holds its last value.
  - Stay while start_process=1.
  - When start_process=0, go to IDLE. The block re-arms only after start_process has been seen low, so a held-high start yields exactly one readout.
- Addressing: RESULT_BASE+index is computed modulo 2^ADDR_WIDTH. Wrap past the top address is legal and silent.
- Dropping start_process mid-operation is ignored; only reset aborts.
- core_done activity outside WAIT_CORES is ignored.
- Latency:
  - start_process rise to WAIT_CORES: 1 cycle.
  - Last done bit to first mem_rd_en: 1 cycle.
  - mem_rd_en to out_valid: 2 cycles.

Test Plan:
- Basic readout:
  - Setup: defaults; memory[0..15]=8'h10..8'h1F; start_process=1; core_done=4'b1111 asserted 10 cycles later; out_ready=1.
  - Required: 16 handshakes with data 0x10..0x1F in order; out_last only on 0x1F; mem_rd_en seen 16 times at addresses 0..15; process_done=1 after, busy=0.
- Staggered sticky done:
  - Stimulus: core_done pulses 4'b0001, 4'b0100, 4'b0010, 4'b1000 on separate cycles.
  - Required: no mem_rd_en until the cycle after the 4'b1000 pulse.
  - Control: a run omitting core 3 never reads.
- Backpressure:
  - Stimulus: out_ready low for 5 cycles while the 3rd element (0x12) is presented.
  - Required: out_valid stays high, out_data=0x12 stable, mem_rd_en low throughout; the stream resumes with 0x13.
- Held start / re-arm:
  - Stimulus: keep start_process=1 after DONE for 50 cycles.
  - Required: no further reads.
  - Then: drop start_process for 1 cycle and raise it again with cores done.
  - Required: a second full 16-element readout.
- Reset mid-stream:
  - Stimulus: assert reset for 1 cycle during PRESENT of element 7.
  - Required: next cycle all outputs 0, state IDLE; a restart begins again at address 0.
- Wrap:
  - Setup: RESULT_BASE=8'hFE, RESULT_COUNT=4.
  - Required: read addresses FE, FF, 00, 01.
